// File: rtl/updi_rx_handler.sv
// UPDI receive-path sequencer: reads bytes from an input FIFO and forwards, acknowledges or discards them.
// Optional stall timeout is compiled in when UPDI_RX_TIMEOUT_EN is defined.
module updi_rx_handler #(
    parameter int         BITS_N    = 8,
    parameter logic [7:0] ACK_VALUE = 8'h40,
    parameter int         TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [BITS_N-1:0]    n_bytes,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 ready,
    output logic                 done,
    output logic                 ack_received,
    output logic                 ack_error,
    output logic                 timeout,
    output logic                 mode_error,
    output logic [BITS_N-1:0]    count,
    input  logic [7:0]           in_fifo_data,
    input  logic                 in_fifo_empty,
    output logic                 in_fifo_rd_en,
    output logic [7:0]           out_fifo_data,
    input  logic                 out_fifo_full,
    output logic                 out_fifo_wr_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_FORWARD,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_READ    = 2'd0;
    localparam logic [1:0] MODE_ACK     = 2'd1;
    localparam logic [1:0] MODE_DISCARD = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    state_t            state;
    logic [1:0]        mode_q;
    logic [BITS_N-1:0] n_q;
    logic [BITS_N-1:0] count_inc;

    assign count_inc = count + 1'b1;

    // Strobes are pure decodes of the state, so they can never outlive the state that owns them.
    assign ready          = (state == S_IDLE);
    assign done           = (state == S_DONE);
    assign in_fifo_rd_en  = (state == S_READ) && !in_fifo_empty;
    assign out_fifo_wr_en = (state == S_FORWARD) && !out_fifo_full;
    assign out_fifo_data  = (state == S_FORWARD) ? in_fifo_data : 8'h00;

`ifdef UPDI_RX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] stall;
    logic [TIMEOUT_W-1:0] limit_q;
    logic [TIMEOUT_W-1:0] stall_inc;

    assign stall_inc = stall + 1'b1;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = &{1'b0, timeout_cycles};
    assign timeout               = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            mode_q       <= MODE_READ;
            n_q          <= '0;
            count        <= '0;
            ack_received <= 1'b0;
            ack_error    <= 1'b0;
            mode_error   <= 1'b0;
`ifdef UPDI_RX_TIMEOUT_EN
            timeout      <= 1'b0;
            stall        <= '0;
            limit_q      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        n_q    <= n_bytes;
                        count  <= '0;
`ifdef UPDI_RX_TIMEOUT_EN
                        stall   <= '0;
                        limit_q <= timeout_cycles;
`endif
                        if (mode == MODE_RSVD) begin
                            mode_error <= 1'b1;
                            state      <= S_DONE;
                        end else if (mode != MODE_ACK && n_bytes == '0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end

                S_READ: begin
                    if (!in_fifo_empty) begin
                        count <= count_inc;
`ifdef UPDI_RX_TIMEOUT_EN
                        stall <= '0;
`endif
                        case (mode_q)
                            MODE_READ:    state <= S_FORWARD;
                            MODE_ACK:     state <= S_CHECK;
                            MODE_DISCARD: state <= (count_inc == n_q) ? S_DONE : S_READ;
                            default:      state <= S_DONE;
                        endcase
                    end
`ifdef UPDI_RX_TIMEOUT_EN
                    else if (limit_q != '0 && stall_inc == limit_q) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        stall <= stall_inc;
                    end
`endif
                end

                S_FORWARD: begin
                    // The FIFO holds its read data until the next rd_en, so waiting here keeps the byte intact.
                    if (!out_fifo_full) begin
                        state <= (count == n_q) ? S_DONE : S_READ;
                    end
                end

                S_CHECK: begin
                    if (in_fifo_data == ACK_VALUE) begin
                        ack_received <= 1'b1;
                    end else begin
                        ack_error <= 1'b1;
                    end
                    state <= S_DONE;
                end

                S_DONE: begin
                    // Status flags are only meaningful alongside done, so they are cleared on the way out.
                    ack_received <= 1'b0;
                    ack_error    <= 1'b0;
                    mode_error   <= 1'b0;
`ifdef UPDI_RX_TIMEOUT_EN
                    timeout      <= 1'b0;
`endif
                    state        <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/updi_rx_handler.md
UPDI_RX_HANDLER -- requirements
Module: updi_rx_handler

Interface
REQ-001 SHALL have parameter BITS_N, default 8, width of n_bytes and count.
REQ-002 SHALL have parameter ACK_VALUE, default 8'h40, byte expected in ACK mode.
REQ-003 SHALL have parameter TIMEOUT_W, default 16, width of timeout_cycles and the internal stall counter.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a transaction; sampled only in IDLE.
- mode  in  2  transaction type: 0 READ (forward bytes), 1 ACK, 2 DISCARD (drain bytes), 3 reserved.
- n_bytes  in  BITS_N  byte count for READ/DISCARD, sampled with start.
- timeout_cycles  in  TIMEOUT_W  stall limit, sampled with start.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when a transaction ends.
- ack_received  out  1  status, valid only while done=1.
- ack_error  out  1  status, valid only while done=1.
- timeout  out  1  status, valid only while done=1.
- mode_error  out  1  status, valid only while done=1.
- count  out  BITS_N  bytes consumed by the current or last transaction.
- in_fifo_data  in  8  input FIFO read data, valid the cycle after in_fifo_rd_en.
- in_fifo_empty  in  1  input FIFO empty.
- in_fifo_rd_en  out  1  input FIFO read strobe.
- out_fifo_data  out  8  output FIFO write data.
- out_fifo_full  in  1  output FIFO full.
- out_fifo_wr_en  out  1  output FIFO write strobe.

Function
REQ-005 SHALL implement states IDLE, READ, FORWARD, CHECK, DONE; all strobes SHALL be driven combinationally from state and inputs, defaulting to 0.
REQ-006 IDLE with start=1 SHALL latch mode, n_bytes and timeout_cycles, clear count, and go to: READ for modes 0/1/2 (n_bytes!=0 or mode 1); DONE for n_bytes==0 in mode 0/2; DONE with mode_error for mode 3. start outside IDLE SHALL be ignored.
REQ-007 READ SHALL assert in_fifo_rd_en iff in_fifo_empty=0; on that cycle count SHALL increment and the next state SHALL be FORWARD (mode 0), CHECK (mode 1), or READ/DONE (mode 2, DONE when count reaches n_bytes).
REQ-008 FORWARD SHALL drive out_fifo_data=in_fifo_data, assert out_fifo_wr_en iff out_fifo_full=0, hold in_fifo_data stable until written, and on write go to DONE when count==n_bytes else READ.
REQ-009 CHECK SHALL compare in_fifo_data with ACK_VALUE, register ack_received on match or ack_error on mismatch, and go to DONE.
REQ-010 DONE SHALL last exactly one cycle with done=1, present exactly the status flags earned by this transaction, and return to IDLE; ready=0 in DONE.
REQ-011 count SHALL hold its value after DONE until the next accepted start or reset; count arithmetic SHALL be modulo 2^BITS_N with n_bytes max 2^BITS_N-1.
REQ-012 Latency: minimum READ byte = 2 cycles (READ, FORWARD), ACK = 2 cycles + DONE, DISCARD = 1 cycle per byte + DONE.
REQ-013 Only one of ack_received/ack_error/timeout/mode_error SHALL be set per transaction.

Reset
REQ-014 rst=1 at any cycle, including mid-transaction, SHALL force IDLE next cycle, clear count, stall counter and all status flags; ready=1, all other outputs 0 after reset; FIFO contents are not restored.

Configuration
REQ-015 With UPDI_RX_TIMEOUT_EN defined, a stall counter SHALL increment each cycle spent in READ with in_fifo_empty=1, clear on each byte read, and when it equals timeout_cycles (non-zero) SHALL go to DONE with timeout=1; timeout_cycles=0 disables it.
REQ-016 Without UPDI_RX_TIMEOUT_EN, no stall counter SHALL exist, timeout SHALL be tied 0, timeout_cycles SHALL be unused, READ waits indefinitely.

Verification
REQ-017 mode=0, n_bytes=3, input FIFO holds 11,22,33 -> output FIFO receives 11,22,33 in order, done once, count=3.
REQ-018 mode=1, input byte 40 -> done with ack_received=1; input byte 41 -> done with ack_error=1, ack_received=0.
REQ-019 mode=0, n_bytes=2, out_fifo_full high 5 cycles during first byte -> wr_en withheld until full drops, data unchanged, no byte lost or duplicated.
REQ-020 mode=2, n_bytes=0 -> done next cycle, no rd_en; mode=3 -> done with mode_error=1.
REQ-021 With UPDI_RX_TIMEOUT_EN, mode=0, n_bytes=2, timeout_cycles=10, one byte then empty -> done with timeout=1 after 10 empty cycles, count=1.
REQ-022 rst pulsed in FORWARD -> next cycle ready=1, count=0, no wr_en, no done.
